pwm_multi: RTL and testbench

- Multi-channel, parametrised PWM generator. Successor to the 4-bit single-channel free-running PWM.
- Adds the following, all sharing one counter:
  - programmable period
  - clock prescaler
  - edge- or center-aligned counting
  - per-channel duty registers, double-buffered (shadow) and updated only at period boundaries
- Drives LED/motor/heater outputs from the control logic.

---
 rtl/pwm_pkg.sv | 19 +
 rtl/pwm_timebase.sv | 88 ++++++++
 rtl/pwm_multi.sv | 123 ++++++++++++
 tb/tb_pwm_multi.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and reset constants for the multi-channel PWM generator.
package pwm_pkg;

    typedef enum logic {
        PWM_EDGE   = 1'b0,
        PWM_CENTER = 1'b1
    } pwm_mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } pwm_dir_e;

    localparam pwm_mode_e RST_MODE  = PWM_EDGE;
    localparam pwm_dir_e  RST_DIR   = DIR_UP;
    localparam logic      RST_LEVEL = 1'b0;
    localparam logic      RST_PULSE = 1'b0;

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: prescaler, up/up-down counter, period boundary
// detection and the registered period_end pulse.
module pwm_timebase
    import pwm_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          period,
    input  pwm_mode_e                 mode,
    output logic [WIDTH-1:0]          count,
    output logic                      boundary,
    output logic                      period_end
);

    logic [PRESCALE_WIDTH-1:0] pre_cnt_q, pre_cnt_d;
    logic [WIDTH-1:0]          cnt_q, cnt_d;
    pwm_dir_e                  dir_q, dir_d;
    logic                      period_end_q, period_end_d;
    logic                      tick;

    // Next-state for prescaler, counter and direction; every boundary returns to 0 counting up
    always_comb begin
        tick      = enable && (pre_cnt_q == prescale);
        pre_cnt_d = pre_cnt_q;
        cnt_d     = cnt_q;
        dir_d     = dir_q;
        boundary  = 1'b0;
        if (enable) begin
            pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;
        end
        if (tick) begin
            if (mode == PWM_EDGE) begin
                if (cnt_q == period) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (period <= WIDTH'(1)) begin
                // Degenerate center period: hold at 0, every tick ends a period
                boundary = 1'b1;
                cnt_d    = '0;
                dir_d    = DIR_UP;
            end else if (dir_q == DIR_UP) begin
                if (cnt_q == period) begin
                    cnt_d = cnt_q - 1'b1;
                    dir_d = DIR_DOWN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else begin
                if (cnt_q == WIDTH'(1)) begin
                    boundary = 1'b1;
                    cnt_d    = '0;
                    dir_d    = DIR_UP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
        end
        period_end_d = boundary;
    end

    // Timebase state registers
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pre_cnt_q    <= '0;
            cnt_q        <= '0;
            dir_q        <= RST_DIR;
            period_end_q <= RST_PULSE;
        end else begin
            pre_cnt_q    <= pre_cnt_d;
            cnt_q        <= cnt_d;
            dir_q        <= dir_d;
            period_end_q <= period_end_d;
        end
    end

    assign count      = cnt_q;
    assign period_end = period_end_q;

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM generator: one shared timebase, per-channel compare
// stages with double-buffered duty, period and mode taken at boundaries.
// Optional build macro PWM_POLARITY_EN adds a per-channel polarity input.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int WIDTH          = 8,
    parameter int CHANNELS       = 4,
    parameter int PRESCALE_WIDTH = 8
) (
    input  logic                      clock,
    input  logic                      reset_n,
    input  logic                      enable,
    input  logic [PRESCALE_WIDTH-1:0] prescale,
    input  logic [WIDTH-1:0]          period,
    input  logic                      center,
    input  logic [CHANNELS*WIDTH-1:0] duty,
    input  logic                      load,
`ifdef PWM_POLARITY_EN
    input  logic [CHANNELS-1:0]       polarity,
`endif
    output logic [CHANNELS-1:0]       signal,
    output logic                      period_end,
    output logic                      update_done
);

    logic [WIDTH-1:0] period_q, period_d;
    pwm_mode_e        mode_q, mode_d;
    logic             pending_q, pending_d;
    logic             update_done_q, update_done_d;
    logic [WIDTH-1:0] count;
    logic             boundary;
    logic             transfer;

    pwm_timebase #(
        .WIDTH          (WIDTH),
        .PRESCALE_WIDTH (PRESCALE_WIDTH)
    ) u_timebase (
        .clock      (clock),
        .reset_n    (reset_n),
        .enable     (enable),
        .prescale   (prescale),
        .period     (period_q),
        .mode       (mode_q),
        .count      (count),
        .boundary   (boundary),
        .period_end (period_end)
    );

    // Shadow transfer control: a load in the boundary cycle counts as pending
    always_comb begin
        transfer      = boundary && (pending_q || load);
        period_d      = period_q;
        mode_d        = mode_q;
        pending_d     = pending_q;
        update_done_d = transfer;
        if (transfer) begin
            period_d  = period;
            mode_d    = pwm_mode_e'(center);
            pending_d = 1'b0;
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // Active period/mode, pending flag and update pulse
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            period_q      <= '1;
            mode_q        <= RST_MODE;
            pending_q     <= 1'b0;
            update_done_q <= RST_PULSE;
        end else begin
            period_q      <= period_d;
            mode_q        <= mode_d;
            pending_q     <= pending_d;
            update_done_q <= update_done_d;
        end
    end

    assign update_done = update_done_q;

`ifdef PWM_POLARITY_EN
    // Polarity is sampled every clock and applied after the active-level flop,
    // so reset and enable-low both leave each output at its inactive level
    logic [CHANNELS-1:0] polarity_q;
    always_ff @(posedge clock) begin
        polarity_q <= polarity;
    end
`endif

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic [WIDTH-1:0] duty_q, duty_d;
        logic             level_q, level_d;

        // Take new duty on transfer; compare uses the pre-update count and duty
        always_comb begin
            duty_d  = duty_q;
            level_d = enable && (count < duty_q);
            if (transfer) begin
                duty_d = duty[gi*WIDTH +: WIDTH];
            end
        end

        // Per-channel active duty and registered active level
        always_ff @(posedge clock or negedge reset_n) begin
            if (!reset_n) begin
                duty_q  <= '0;
                level_q <= RST_LEVEL;
            end else begin
                duty_q  <= duty_d;
                level_q <= level_d;
            end
        end

`ifdef PWM_POLARITY_EN
        assign signal[gi] = level_q ^ polarity_q[gi];
`else
        assign signal[gi] = level_q;
`endif
    end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed testbench for pwm_multi (default build, WIDTH=8, CHANNELS=4).
module tb_pwm_multi;

    localparam int W  = 8;
    localparam int CH = 4;
    localparam int PW = 8;

    logic            clock    = 1'b0;
    logic            reset_n  = 1'b0;
    logic            enable   = 1'b0;
    logic [PW-1:0]   prescale = '0;
    logic [W-1:0]    period   = '0;
    logic            center   = 1'b0;
    logic [CH*W-1:0] duty     = '0;
    logic            load     = 1'b0;
`ifdef PWM_POLARITY_EN
    logic [CH-1:0]   polarity = '0;
`endif
    logic [CH-1:0]   signal;
    logic            period_end;
    logic            update_done;

    int tests = 0;
    int fails = 0;

    always #5 clock = ~clock;

    pwm_multi #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_WIDTH(PW)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .enable      (enable),
        .prescale    (prescale),
        .period      (period),
        .center      (center),
        .duty        (duty),
        .load        (load),
`ifdef PWM_POLARITY_EN
        .polarity    (polarity),
`endif
        .signal      (signal),
        .period_end  (period_end),
        .update_done (update_done)
    );

    task automatic set_duty(input int d0, input int d1, input int d2, input int d3);
        duty = {W'(d3), W'(d2), W'(d1), W'(d0)};
    endtask

    // Pulse load for one clock and wait (bounded) for the update_done pulse
    task automatic load_and_wait(input string name);
        bit seen = 0;
        load = 1'b1;
        for (int n = 0; n < 1000; n++) begin
            @(negedge clock);
            load = 1'b0;
            if (update_done === 1'b1) begin
                seen = 1;
                break;
            end
        end
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s_update_timeout got no update_done want pulse within 1000 clocks", name);
        end else begin
            tests++;
            if (period_end !== 1'b1) begin
                fails++;
                $display("FAIL %s_pe_with_update got %b want 1", name, period_end);
            end
        end
        $display("[TB] %s: shadow load applied", name);
    endtask

    // Edge-mode waveform check for nsamp clocks following update_done
    task automatic check_edge(input string name, input int nsamp, input int p, input int presc,
                              input int d0, input int d1, input int d2, input int d3);
        int c;
        int d[4];
        logic [CH-1:0] exp_sig;
        logic exp_pe;
        d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
        for (int j = 1; j <= nsamp; j++) begin
            @(negedge clock);
            c = ((j - 1) / (presc + 1)) % (p + 1);
            for (int k = 0; k < CH; k++) exp_sig[k] = (c < d[k]);
            exp_pe = ((j % ((p + 1) * (presc + 1))) == 0);
            tests++;
            if (signal !== exp_sig) begin
                fails++;
                $display("FAIL %s_signal j=%0d got %b want %b", name, j, signal, exp_sig);
            end
            tests++;
            if (period_end !== exp_pe) begin
                fails++;
                $display("FAIL %s_period_end j=%0d got %b want %b", name, j, period_end, exp_pe);
            end
        end
        $display("[TB] %s: %0d clocks checked", name, nsamp);
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clock);
        tests++;
        if (signal !== 4'b0000) begin
            fails++;
            $display("FAIL reset_signal got %b want 0000", signal);
        end
        tests++;
        if (period_end !== 1'b0) begin
            fails++;
            $display("FAIL reset_period_end got %b want 0", period_end);
        end
        tests++;
        if (update_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_update_done got %b want 0", update_done);
        end
        reset_n = 1'b1;
        $display("[TB] reset: outputs checked, reset released");
    endtask

    task automatic test_edge_basic;
        enable   = 1'b1;
        prescale = 8'd0;
        center   = 1'b0;
        period   = 8'd9;
        set_duty(3, 0, 10, 5);
        load_and_wait("edge_basic");
        check_edge("edge_basic", 20, 9, 0, 3, 0, 10, 5);
    endtask

    task automatic test_prescaler;
        prescale = 8'd2;
        period   = 8'd3;
        set_duty(2, 0, 10, 5);
        load_and_wait("prescaler");
        check_edge("prescaler", 24, 3, 2, 2, 0, 10, 5);
    endtask

    task automatic test_center;
        int seq[8];
        int c;
        logic [CH-1:0] exp_sig;
        logic exp_pe;
        seq = '{0, 1, 2, 3, 4, 3, 2, 1};
        prescale = 8'd0;
        center   = 1'b1;
        period   = 8'd4;
        set_duty(2, 0, 10, 5);
        load_and_wait("center");
        for (int j = 1; j <= 16; j++) begin
            @(negedge clock);
            c = seq[(j - 1) % 8];
            exp_sig = {1'(c < 5), 1'b1, 1'b0, 1'(c < 2)};
            exp_pe  = ((j % 8) == 0);
            tests++;
            if (signal !== exp_sig) begin
                fails++;
                $display("FAIL center_signal j=%0d got %b want %b", j, signal, exp_sig);
            end
            tests++;
            if (period_end !== exp_pe) begin
                fails++;
                $display("FAIL center_period_end j=%0d got %b want %b", j, period_end, exp_pe);
            end
        end
        $display("[TB] center: 16 clocks checked");
    endtask

    // Mid-period load (plus an absorbed second pulse), then a load on the boundary cycle
    task automatic test_shadow;
        int c;
        int dcur;
        logic [CH-1:0] exp_sig;
        logic exp_pe;
        logic exp_ud;
        center = 1'b0;
        period = 8'd9;
        set_duty(3, 0, 10, 5);
        load_and_wait("shadow");
        for (int j = 1; j <= 30; j++) begin
            @(negedge clock);
            c      = (j - 1) % 10;
            dcur   = (j <= 10) ? 3 : ((j <= 20) ? 7 : 2);
            exp_sig = {1'(c < 5), 1'b1, 1'b0, 1'(c < dcur)};
            exp_pe = ((j % 10) == 0);
            exp_ud = (j == 10) || (j == 20);
            tests++;
            if (signal !== exp_sig) begin
                fails++;
                $display("FAIL shadow_signal j=%0d got %b want %b", j, signal, exp_sig);
            end
            tests++;
            if (period_end !== exp_pe) begin
                fails++;
                $display("FAIL shadow_period_end j=%0d got %b want %b", j, period_end, exp_pe);
            end
            tests++;
            if (update_done !== exp_ud) begin
                fails++;
                $display("FAIL shadow_update_done j=%0d got %b want %b", j, update_done, exp_ud);
            end
            if (j == 4 || j == 6) begin
                duty[7:0] = 8'd7;
                load = 1'b1;
            end else if (j == 19) begin
                duty[7:0] = 8'd2;
                load = 1'b1;
            end else begin
                load = 1'b0;
            end
        end
        $display("[TB] shadow: 30 clocks checked");
    endtask

    // Continues from the boundary that ends test_shadow (count 0, duty0=2, duty3=5)
    task automatic test_enable;
        int c;
        logic [CH-1:0] exp_sig;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clock);
            tests++;
            if (signal !== 4'b1101) begin
                fails++;
                $display("FAIL enable_pre k=%0d got %b want 1101", k, signal);
            end
        end
        enable = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clock);
            tests++;
            if (signal !== 4'b0000 || period_end !== 1'b0) begin
                fails++;
                $display("FAIL enable_low k=%0d got sig=%b pe=%b want sig=0000 pe=0", k, signal, period_end);
            end
        end
        enable = 1'b1;
        for (int m = 1; m <= 8; m++) begin
            @(negedge clock);
            c = m + 1;
            exp_sig = {1'(c < 5), 1'b1, 1'b0, 1'(c < 2)};
            tests++;
            if (signal !== exp_sig) begin
                fails++;
                $display("FAIL enable_resume_signal m=%0d got %b want %b", m, signal, exp_sig);
            end
            tests++;
            if (period_end !== (m == 8)) begin
                fails++;
                $display("FAIL enable_resume_pe m=%0d got %b want %b", m, period_end, (m == 8));
            end
        end
        $display("[TB] enable: freeze and resume checked");
    endtask

    task automatic test_reset_mid;
        int ud_count = 0;
        int hi_count = 0;
        int first_pe = -1;
        repeat (3) @(negedge clock);
        duty[7:0] = 8'd8;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        tests++;
        if (signal[2] !== 1'b1) begin
            fails++;
            $display("FAIL reset_mid_pre got ch2=%b want 1", signal[2]);
        end
        #2 reset_n = 1'b0;
        #1;
        tests++;
        if (signal !== 4'b0000 || period_end !== 1'b0 || update_done !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_async got sig=%b pe=%b ud=%b want 0000 0 0", signal, period_end, update_done);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        for (int n = 1; n <= 300; n++) begin
            @(negedge clock);
            if (update_done === 1'b1) ud_count++;
            if (signal !== 4'b0000) hi_count++;
            if (period_end === 1'b1 && first_pe < 0) first_pe = n;
        end
        tests++;
        if (ud_count != 0) begin
            fails++;
            $display("FAIL reset_mid_pending got %0d updates want 0", ud_count);
        end
        tests++;
        if (hi_count != 0) begin
            fails++;
            $display("FAIL reset_mid_signal got %0d high clocks want 0", hi_count);
        end
        tests++;
        if (first_pe != 256) begin
            fails++;
            $display("FAIL reset_mid_period got first period_end at %0d want 256", first_pe);
        end
        $display("[TB] reset_mid: pending discarded, defaults restored");
    endtask

    initial begin
        test_reset();
        test_edge_basic();
        test_prescaler();
        test_center();
        test_shadow();
        test_enable();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
